// File: rtl/fp16_output_stage_if.sv
// Handshake bundle between the normalization stage, the FP16 output stage and its consumer.
// The output stage connects through the slave modport.
interface fp16_output_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [10:0] norm_sum;
    logic [6:0]  exp_final;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;

    modport master (
        output in_valid, sign, norm_sum, exp_final, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, sign, norm_sum, exp_final, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/fp16_output_stage.sv
// FP16 packing stage: one-entry capture register, then round-toward-zero conversion into a small
// output FIFO, with saturating counts of overflowed and subnormal/flushed results.
module fp16_output_stage #(
    parameter int FIFO_DEPTH = 4,
    parameter int BIAS       = 15
) (
    input  logic                clk,
    input  logic                rst,
    fp16_output_stage_if.slave  bus,
    output logic [7:0]          ovf_cnt,
    output logic [7:0]          sub_cnt
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW+1:0]      DEPTH_W    = (PW+2)'(FIFO_DEPTH);
    localparam logic signed [7:0]  EXP_INF    = 8'(2*BIAS + 1);
    localparam logic signed [7:0]  SHIFT_ZERO = 8'sd11;

    logic              s1_valid_reg;
    logic              s1_sign_reg;
    logic [10:0]       s1_sum_reg;
    logic [6:0]        s1_exp_reg;
    logic [15:0]       mem_reg [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW:0]       count_reg;
    logic [7:0]        ovf_cnt_reg;
    logic [7:0]        sub_cnt_reg;

    logic [PW+1:0]     occupancy;
    logic              accept;
    logic              push;
    logic              pop;
    logic signed [7:0] exp_ext;
    logic signed [7:0] shift_amt;
    logic [10:0]       shifted;
    logic [15:0]       conv_word;
    logic              conv_ovf;
    logic              conv_sub;

    // Readiness counts the staged entry too, so the FIFO can never be pushed while full.
    assign occupancy     = {1'b0, count_reg} + {{(PW+1){1'b0}}, s1_valid_reg};
    assign bus.in_ready  = occupancy < DEPTH_W;
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = s1_valid_reg;
    assign bus.out_valid = count_reg != '0;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out       = bus.out_valid ? mem_reg[rd_ptr_reg] : 16'h0000;
    assign ovf_cnt       = ovf_cnt_reg;
    assign sub_cnt       = sub_cnt_reg;

    assign exp_ext   = {s1_exp_reg[6], s1_exp_reg};
    assign shift_amt = 8'sd1 - exp_ext;
    assign shifted   = s1_sum_reg >> shift_amt[3:0];

    always_comb begin
        conv_word = {s1_sign_reg, 15'b0};
        conv_ovf  = 1'b0;
        conv_sub  = 1'b0;
        if (s1_sum_reg == 11'd0) begin
            conv_word = {s1_sign_reg, 15'b0};
        end else if (exp_ext >= EXP_INF) begin
            conv_word = {s1_sign_reg, 5'b11111, 10'b0};
            conv_ovf  = 1'b1;
        end else if (exp_ext >= 8'sd1) begin
            conv_word = {s1_sign_reg, s1_exp_reg[4:0], s1_sum_reg[9:0]};
        end else begin
            conv_sub = 1'b1;
            // Shifts of 11 or more push the hidden bit past the fraction entirely.
            if (shift_amt >= SHIFT_ZERO)
                conv_word = {s1_sign_reg, 15'b0};
            else
                conv_word = {s1_sign_reg, 5'b0, shifted[9:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_sum_reg   <= '0;
            s1_exp_reg   <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ovf_cnt_reg  <= '0;
            sub_cnt_reg  <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_sign_reg  <= bus.sign;
                s1_sum_reg   <= bus.norm_sum;
                s1_exp_reg   <= bus.exp_final;
            end else if (push) begin
                s1_valid_reg <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (conv_ovf && ovf_cnt_reg != 8'hFF)
                    ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
                if (conv_sub && sub_cnt_reg != 8'hFF)
                    sub_cnt_reg <= sub_cnt_reg + 8'd1;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem_reg[wr_ptr_reg] <= conv_word;
    end
endmodule
